// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit positions, default squash mask
// and operand-forwarding select encodings.
package mips_pipe_pkg;

    localparam int CTRL_W_DEF      = 24;
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_CP0_WRITE  = 1;
    localparam int CTRL_MEM_WEN    = 2;
    localparam int CTRL_MEM_REN    = 3;
    localparam int CTRL_JUMP       = 4;
    localparam int CTRL_BRANCH     = 5;

    localparam logic [CTRL_W_DEF-1:0] KILL_MASK_DEF = 24'hFFFFFF;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXE = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready register slice; SKID_EN adds a second entry so that
// in_ready comes from a flop instead of combinationally from out_ready.
module pipe_skid_buf #(
    parameter int WIDTH   = 8,
    parameter bit SKID_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    generate
        if (SKID_EN) begin : g_skid
            logic             skid_valid_q, skid_valid_d, out_valid_d, accept;
            logic [WIDTH-1:0] skid_data_q, skid_data_d, out_data_d;

            assign in_ready = !skid_valid_q;
            assign accept   = in_valid && !skid_valid_q && !flush;

            always_comb begin
                out_valid_d  = out_valid_q;
                out_data_d   = out_data_q;
                skid_valid_d = skid_valid_q;
                skid_data_d  = skid_data_q;
                if (flush) begin
                    out_valid_d  = 1'b0;
                    skid_valid_d = 1'b0;
                end else if (!out_valid_q || out_ready) begin
                    // Parked beat is older than anything upstream, so it drains first.
                    if (skid_valid_q) begin
                        out_valid_d  = 1'b1;
                        out_data_d   = skid_data_q;
                        skid_valid_d = 1'b0;
                    end else begin
                        out_valid_d = accept;
                        if (accept) out_data_d = in_data;
                    end
                end else if (accept) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = in_data;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    out_valid_q  <= 1'b0;
                    out_data_q   <= '0;
                    skid_valid_q <= 1'b0;
                    skid_data_q  <= '0;
                end else begin
                    out_valid_q  <= out_valid_d;
                    out_data_q   <= out_data_d;
                    skid_valid_q <= skid_valid_d;
                    skid_data_q  <= skid_data_d;
                end
            end
        end else begin : g_single
            logic             out_valid_d, accept;
            logic [WIDTH-1:0] out_data_d;

            assign in_ready = !out_valid_q || out_ready;
            assign accept   = in_valid && in_ready && !flush;

            always_comb begin
                out_valid_d = out_valid_q;
                out_data_d  = out_data_q;
                if (flush) begin
                    out_valid_d = 1'b0;
                end else if (in_ready) begin
                    out_valid_d = accept;
                    if (accept) out_data_d = in_data;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                end else begin
                    out_valid_q <= out_valid_d;
                    out_data_q  <= out_data_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/decode_pipe_stage.sv
// Decode-to-execute pipeline stage with operand forwarding, squash masking and
// a saturating stall counter. Define DECODE_PIPE_SKID_EN for the two-entry skid build.
module decode_pipe_stage
    import mips_pipe_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                CTRL_W    = 24,
    parameter int                NUM_FWD   = 3,
    parameter logic [CTRL_W-1:0] KILL_MASK = CTRL_W'(KILL_MASK_DEF),
    parameter int                CNT_W     = 16,
    localparam int               SEL_W     = $clog2(NUM_FWD + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_pc,
    input  logic [31:0]               in_inst,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic                      in_bad,
    input  logic [DATA_W-1:0]         rf_a,
    input  logic [DATA_W-1:0]         rf_b,
    input  logic [SEL_W-1:0]          fwd_sel_a,
    input  logic [SEL_W-1:0]          fwd_sel_b,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_pc,
    output logic [31:0]               out_inst,
    output logic [DATA_W-1:0]         out_a,
    output logic [DATA_W-1:0]         out_b,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic                      out_bad,
    output logic [CNT_W-1:0]          stall_cnt
);

`ifdef DECODE_PIPE_SKID_EN
    localparam bit SKID_EN = 1'b1;
`else
    localparam bit SKID_EN = 1'b0;
`endif

    localparam int PAY_W = 3 * DATA_W + 32 + CTRL_W + 1;

    // Priority chain seeded with the register file; out-of-range selects fall through to it.
    logic [DATA_W-1:0] chain_a [NUM_FWD+1];
    logic [DATA_W-1:0] chain_b [NUM_FWD+1];

    assign chain_a[0] = rf_a;
    assign chain_b[0] = rf_b;

    generate
        for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_fwd
            assign chain_a[gi+1] = (fwd_sel_a == SEL_W'(gi + 1)) ?
                                   fwd_data[gi*DATA_W +: DATA_W] : chain_a[gi];
            assign chain_b[gi+1] = (fwd_sel_b == SEL_W'(gi + 1)) ?
                                   fwd_data[gi*DATA_W +: DATA_W] : chain_b[gi];
        end
    endgenerate

    logic [CTRL_W-1:0] ctrl_d;
    logic [PAY_W-1:0]  pay_in, pay_out;

    assign ctrl_d = in_bad ? (in_ctrl & ~KILL_MASK) : in_ctrl;
    assign pay_in = {in_pc, in_inst, chain_a[NUM_FWD], chain_b[NUM_FWD], ctrl_d, in_bad};
    assign {out_pc, out_inst, out_a, out_b, out_ctrl, out_bad} = pay_out;

    pipe_skid_buf #(
        .WIDTH   (PAY_W),
        .SKID_EN (SKID_EN)
    ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out)
    );

    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_q <= '0;
        else      stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;

endmodule
